div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Scheduler that shares the single iterative `divider` between NUM_REQ requesters (e.g. the integer RS and the address-gen RS).
- Round-robin arbitration; sequences the divider's start/done handshake; returns results on one tagged response channel with backpressure.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without starting the divider.
- Caches the last computed quotient/remainder pair so a following DIV/REM pair with the same operands costs one cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- TAG_W, 4, width of the requester-supplied tag returned with the result

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_op  in  NUM_REQ*3  per-requester mult_funct3_t (div, divu, rem, remu)
- req_a  in  NUM_REQ*32  per-requester dividend
- req_b  in  NUM_REQ*32  per-requester divisor
- req_tag  in  NUM_REQ*TAG_W  per-requester tag
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  quotient or remainder
- resp_tag  out  TAG_W  tag of the owning request
- resp_src  out  $clog2(NUM_REQ)  index of the owning requester
- resp_err  out  1  op was not a divide-class funct3
- div_start  out  1  one-cycle start pulse to divider
- div_op  out  3  op to divider
- dividend  out  32  to divider
- divisor  out  32  to divider
- quotient  in  32  from divider
- remainder  in  32  from divider
- div_done  in  1  divider result valid (single-cycle pulse)
- div_stall  in  1  divider busy

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE; req_ready=0, resp_valid=0, div_start=0, resp_err=0.
  - resp_data/tag/src, dividend, divisor, div_op = 0.
  - rr pointer=0; cache invalid.
- Request acceptance:
  - req_ready is high only in IDLE, only when !div_stall, and only for the granted index.
  - Grant goes to the first valid requester at or after the rr pointer, searching upward with wrap.
  - On accept (valid&ready), the operands, op, tag and src are latched, and rr pointer = granted index+1 mod NUM_REQ.
- State machine (IDLE, ISSUE, WAIT, RESP):
  - IDLE -> RESP on accept if the fast path applies; else IDLE -> ISSUE.
  - ISSUE: div_start=1 for exactly this cycle, with dividend/divisor/div_op driven from the latch (held stable through WAIT). -> WAIT.
  - WAIT: on div_done, capture quotient and remainder into the cache, select the result, -> RESP.
  - RESP: resp_valid=1 with all resp_* stable until resp_ready. On resp_valid&resp_ready -> IDLE; a new accept is possible in the following cycle.
- Fast path (result ready in RESP the cycle after accept):
  - op[2]==0 (mul class): resp_data=0, resp_err=1.
  - divisor==0: div/divu -> 32'hFFFFFFFF; rem/remu -> dividend.
  - div with a=32'h80000000, b=32'hFFFFFFFF: resp_data=32'h80000000. rem with the same operands: resp_data=0.
  - Cache hit: cache valid, a and b equal to the cached operands, and op[0] (signedness) equal to the cached signedness. resp_data is taken from the cached quotient (op[1]==0) or cached remainder (op[1]==1).
- Result select: div/divu -> quotient; rem/remu -> remainder.
- Cache update: written only on div_done in WAIT. The special-case paths never write it.
- Stray div_done outside WAIT is ignored: no state change and no cache write.
- Latency:
  - Fast path: accept at T, resp_valid at T+1.
  - Divider path: accept at T, div_start at T+1, resp_valid the cycle after div_done.
- Reset mid-operation: the FSM goes to IDLE and the cache is invalidated. After reset release, no issue occurs while div_stall=1, so a divider still finishing an orphan operation is waited out.

Decomposition:
- Package mult_funct3 (existing) supplies mult_funct3_t.
- New div_sched_pkg holds:
  - the state enum div_sched_state_t;
  - constants DIV_ZERO_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Sub-module div_rr_arb (parameter NUM_REQ; inputs valid vector and pointer; outputs one-hot grant and index). Purely combinational; the pointer register lives in div_sched.

Test Plan:
- Single request, req0: div 15/4, tag 3 -> one div_start pulse; resp_data=3, resp_tag=3, resp_src=0, resp_err=0.
- req0 and req1 both valid and held across four transactions, ops divu 100/7 -> grants alternate 0,1,0,1; each resp_data=14.
- Divide-by-zero fast path:
  - rem -18/0 -> resp_data=-18 at T+1, div_start never asserted.
  - divu 5/0 -> 32'hFFFFFFFF.
- Overflow fast path:
  - div 32'h80000000/-1 -> 32'h80000000.
  - rem 32'h80000000/-1 -> 0; no div_start in either case.
- Cache: div -18/7 then rem -18/7 -> first response -2 via divider; second response -4 at T+1 with no div_start. A following remu -18/7 misses the cache and starts the divider.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0 throughout.
  - Assert rst_n low during WAIT with div_stall=1 -> all outputs go to their reset values. After release, no issue until div_stall=0; the stray div_done is ignored.

Source files
------------

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - types and constants for the shared divider scheduler
package div_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } div_sched_state_t;

    // RISC-V results that never need the divider
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mult_funct3.sv
// rtl/mult_funct3.sv - RISC-V M-extension funct3 encodings shared by the mul/div units
package mult_funct3;

    // bit 2 selects the divide class, bit 1 selects remainder, bit 0 selects unsigned
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mult_funct3_t;

endpackage

// File: rtl/div_sched_if.sv
// rtl/div_sched_if.sv - requester and response channels of the divider scheduler
interface div_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [NUM_REQ*32-1:0]    req_a;
    logic [NUM_REQ*32-1:0]    req_b;
    logic [NUM_REQ*TAG_W-1:0] req_tag;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [31:0]              resp_data;
    logic [TAG_W-1:0]         resp_tag;
    logic [SRC_W-1:0]         resp_src;
    logic                     resp_err;

    // requesters plus the response consumer
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_src, resp_err
    );

    // the scheduler
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, resp_src, resp_err
    );

endinterface

// File: rtl/div_rr_arb.sv
// rtl/div_rr_arb.sv - combinational round-robin pick starting at a pointer
module div_rr_arb #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // first valid requester at or above ptr, wrapping around
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - shares one iterative divider between requesters, with special-case and pair cache
module div_sched import mult_funct3::*; import div_sched_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    div_sched_if.slave  bus,
    output logic        div_start,
    output logic [2:0]  div_op,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    input  logic        div_done,
    input  logic        div_stall
);

    localparam int IDX_W = $clog2(NUM_REQ);

    div_sched_state_t state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d, src_q, src_d;
    logic             en_q, en_d;
    logic [31:0]      a_q, a_d, b_q, b_d, data_q, data_d;
    mult_funct3_t     op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic             cache_vld_q, cache_vld_d, cache_uns_q, cache_uns_d;
    logic [31:0]      cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic [31:0]      cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_found, accept;
    logic [31:0]        a_sel, b_sel, fast_data;
    mult_funct3_t       op_sel;
    logic [TAG_W-1:0]   tag_sel;
    logic               fast, fast_err, cache_hit;

    div_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid (bus.req_valid),
        .ptr   (rr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    // en_q holds off grants for the first cycle after reset so req_ready stays low while reset is applied
    assign accept         = en_q && (state_q == S_IDLE) && !div_stall && gnt_found;
    assign bus.req_ready  = accept ? gnt : '0;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_data  = data_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_src   = src_q;
    assign bus.resp_err   = err_q;
    assign div_start      = (state_q == S_ISSUE);
    assign div_op         = op_q;
    assign dividend       = a_q;
    assign divisor        = b_q;

    // pull the granted requester's fields out of the packed buses
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        op_sel  = F3_MUL;
        tag_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == gnt_idx) begin
                a_sel   = bus.req_a[k*32 +: 32];
                b_sel   = bus.req_b[k*32 +: 32];
                op_sel  = mult_funct3_t'(bus.req_op[k*3 +: 3]);
                tag_sel = bus.req_tag[k*TAG_W +: TAG_W];
            end
        end
    end

    // results known at accept time: non-divide ops, divide by zero, signed overflow, cache hit
    always_comb begin
        fast      = 1'b1;
        fast_data = '0;
        fast_err  = 1'b0;
        cache_hit = cache_vld_q && (a_sel == cache_a_q) && (b_sel == cache_b_q)
                    && (op_sel[0] == cache_uns_q);
        if (!op_sel[2]) begin
            fast_err = 1'b1;
        end else if (b_sel == '0) begin
            fast_data = op_sel[1] ? a_sel : DIV_ZERO_Q;
        end else if (!op_sel[0] && (a_sel == INT_MIN) && (b_sel == 32'hFFFF_FFFF)) begin
            fast_data = op_sel[1] ? 32'd0 : INT_MIN;
        end else if (cache_hit) begin
            fast_data = op_sel[1] ? cache_rem_q : cache_quo_q;
        end else begin
            fast = 1'b0;
        end
    end

    // scheduler FSM: accept, issue, wait for the divider, hold the response
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        en_d        = 1'b1;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        tag_d       = tag_q;
        src_d       = src_q;
        data_d      = data_q;
        err_d       = err_q;
        cache_vld_d = cache_vld_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_uns_d = cache_uns_q;
        cache_quo_d = cache_quo_q;
        cache_rem_d = cache_rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d   = a_sel;
                    b_d   = b_sel;
                    op_d  = op_sel;
                    tag_d = tag_sel;
                    src_d = gnt_idx;
                    rr_d  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    if (fast) begin
                        data_d  = fast_data;
                        err_d   = fast_err;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (div_done) begin
                    cache_vld_d = 1'b1;
                    cache_a_d   = a_q;
                    cache_b_d   = b_q;
                    cache_uns_d = op_q[0];
                    cache_quo_d = quotient;
                    cache_rem_d = remainder;
                    data_d      = op_q[1] ? remainder : quotient;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset also drops the cached pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            en_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= F3_MUL;
            tag_q       <= '0;
            src_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cache_vld_q <= 1'b0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_uns_q <= 1'b0;
            cache_quo_q <= '0;
            cache_rem_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            en_q        <= en_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            src_q       <= src_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cache_vld_q <= cache_vld_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_uns_q <= cache_uns_d;
            cache_quo_q <= cache_quo_d;
            cache_rem_q <= cache_rem_d;
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - self-checking bench for div_sched with a behavioural divider
module tb_div_sched;
    import mult_funct3::*;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

    logic        div_start, div_done, div_stall;
    logic [2:0]  div_op;
    logic [31:0] dividend, divisor, quotient, remainder;

    div_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .div_start (div_start),
        .div_op    (div_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_done  (div_done),
        .div_stall (div_stall)
    );

    // behavioural divider: busy four cycles after start, then a one-cycle done
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_q = '0, m_r = '0;
    logic        stall_force = 1'b0, stray_done = 1'b0;
    assign div_stall = m_busy | stall_force;
    assign div_done  = m_done | stray_done;
    assign quotient  = m_q;
    assign remainder = m_r;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 3;
            if (div_op[0]) begin
                m_q <= dividend / divisor;
                m_r <= dividend % divisor;
            end else begin
                m_q <= $signed(dividend) / $signed(divisor);
                m_r <= $signed(dividend) % $signed(divisor);
            end
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // cycle counter and divider handshake history
    int cyc = 0, start_cnt = 0, start_cyc = -1, done_cyc = -1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (div_done) done_cyc <= cyc;
    end

    typedef struct {
        int               src;
        logic [2:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             err;
        logic             fast;
    } vec_t;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        int               src;
        logic             err;
    } exp_t;

    vec_t vt[12];
    exp_t sb[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input int src, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bus.req_valid[src]           = 1'b1;
        bus.req_op[src*3 +: 3]       = op;
        bus.req_a[src*32 +: 32]      = a;
        bus.req_b[src*32 +: 32]      = b;
        bus.req_tag[src*TAG_W +: TAG_W] = tag;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [TAG_W-1:0] tag,
                            input int src, input logic err);
        exp_t e;
        e.data = data;
        e.tag  = tag;
        e.src  = src;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int src, output bit ok);
        int t = 0;
        while (bus.req_ready[src] !== 1'b1 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        ok = (bus.req_ready[src] === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout src%0d: req_ready got 0 required 1", src);
        end
    endtask

    task automatic wait_resp(input string name, output int rc);
        exp_t e;
        int   t = 0;
        while (bus.resp_valid !== 1'b1 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        rc = cyc;
        if (sb.size() == 0) begin
            chk({name, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        if (bus.resp_valid !== 1'b1) begin
            chk({name, ".resp_timeout"}, 32'(bus.resp_valid), 32'd1);
            return;
        end
        chk({name, ".data"}, bus.resp_data, e.data);
        chk({name, ".tag"},  32'(bus.resp_tag), 32'(e.tag));
        chk({name, ".src"},  32'(bus.resp_src), e.src);
        chk({name, ".err"},  32'(bus.resp_err), 32'(e.err));
        @(negedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit ok;
        int k, s0, rc;
        @(negedge clk); #1;
        drive(v.src, v.op, v.a, v.b, v.tag);
        #1;
        wait_ready(v.src, ok);
        if (!ok) begin
            bus.req_valid[v.src] = 1'b0;
            return;
        end
        k  = cyc;
        s0 = start_cnt;
        push_exp(v.data, v.tag, v.src, v.err);
        @(negedge clk); #1;
        bus.req_valid[v.src] = 1'b0;
        if (v.fast) chk({name, ".no_start_pulse"}, 32'(div_start), 32'd0);
        wait_resp(name, rc);
        if (v.fast) begin
            chk({name, ".fast_latency"}, rc, k + 1);
            chk({name, ".fast_starts"}, start_cnt, s0);
        end else begin
            chk({name, ".starts"}, start_cnt, s0 + 1);
            chk({name, ".start_cycle"}, start_cyc, k + 1);
            chk({name, ".resp_after_done"}, rc, done_cyc + 1);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".req_ready"},  32'(bus.req_ready), 32'd0);
        chk({name, ".resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({name, ".div_start"},  32'(div_start), 32'd0);
        chk({name, ".resp_err"},   32'(bus.resp_err), 32'd0);
        chk({name, ".resp_data"},  bus.resp_data, 32'd0);
        chk({name, ".resp_tag"},   32'(bus.resp_tag), 32'd0);
        chk({name, ".resp_src"},   32'(bus.resp_src), 32'd0);
        chk({name, ".dividend"},   dividend, 32'd0);
        chk({name, ".divisor"},    divisor, 32'd0);
        chk({name, ".div_op"},     32'(div_op), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   t, s0, rc, g;
        vec_t vr;

        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;

        vt[0]  = '{0, F3_DIV,  32'd15,         32'd4,          4'd3,  32'd3,          1'b0, 1'b0};
        vt[1]  = '{1, F3_REM,  32'hFFFF_FFEE,  32'd0,          4'd5,  32'hFFFF_FFEE,  1'b0, 1'b1};
        vt[2]  = '{0, F3_DIVU, 32'd5,          32'd0,          4'd1,  32'hFFFF_FFFF,  1'b0, 1'b1};
        vt[3]  = '{1, F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  4'd2,  32'h8000_0000,  1'b0, 1'b1};
        vt[4]  = '{0, F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  4'd4,  32'd0,          1'b0, 1'b1};
        vt[5]  = '{0, F3_DIV,  32'hFFFF_FFEE,  32'd7,          4'd6,  32'hFFFF_FFFE,  1'b0, 1'b0};
        vt[6]  = '{1, F3_REM,  32'hFFFF_FFEE,  32'd7,          4'd7,  32'hFFFF_FFFC,  1'b0, 1'b1};
        vt[7]  = '{0, F3_REMU, 32'hFFFF_FFEE,  32'd7,          4'd8,  32'd0,          1'b0, 1'b0};
        vt[8]  = '{1, F3_MUL,  32'd3,          32'd4,          4'd9,  32'd0,          1'b1, 1'b1};
        vt[9]  = '{0, F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  4'd10, 32'd0,          1'b0, 1'b0};
        vt[10] = '{1, F3_REM,  32'd7,          32'hFFFF_FFFD,  4'd11, 32'd1,          1'b0, 1'b0};
        vt[11] = '{1, F3_DIV,  32'd7,          32'hFFFF_FFFD,  4'd12, 32'hFFFF_FFFE,  1'b0, 1'b1};

        // reset state, with a requester already asking
        @(negedge clk); #1;
        bus.req_valid = 2'b01;
        #1;
        chk_reset_outputs("reset");
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // both requesters held valid: grants alternate 0,1,0,1; only the first needs the divider
        drive(0, F3_DIVU, 32'd100, 32'd7, 4'd1);
        drive(1, F3_DIVU, 32'd100, 32'd7, 4'd2);
        #1;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            t = 0;
            while (bus.req_ready === '0 && t < 200) begin
                @(negedge clk); #1;
                t++;
            end
            chk($sformatf("alt%0d.grant", i), 32'(bus.req_ready), (g == 0) ? 32'd1 : 32'd2);
            push_exp(32'd14, (g == 0) ? 4'd1 : 4'd2, g, 1'b0);
            @(negedge clk); #1;
            wait_resp($sformatf("alt%0d", i), rc);
        end
        bus.req_valid = '0;
        chk("alt.starts", start_cnt - s0, 32'd1);

        // table of single requests
        for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // backpressure: response held for five cycles while the other requester waits
        @(negedge clk); #1;
        bus.resp_ready = 1'b0;
        drive(0, F3_DIV, 32'd15, 32'd4, 4'd9);
        drive(1, F3_DIVU, 32'd1, 32'd1, 4'd0);
        #1;
        wait_ready(0, ok);
        push_exp(32'd3, 4'd9, 0, 1'b0);
        @(negedge clk); #1;
        bus.req_valid[0] = 1'b0;
        t = 0;
        while (bus.resp_valid !== 1'b1 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.valid", i), 32'(bus.resp_valid), 32'd1);
            chk($sformatf("bp%0d.data", i), bus.resp_data, 32'd3);
            chk($sformatf("bp%0d.tag", i), 32'(bus.resp_tag), 32'd9);
            chk($sformatf("bp%0d.req_ready", i), 32'(bus.req_ready), 32'd0);
            @(negedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        wait_resp("bp", rc);
        bus.req_valid[1] = 1'b0;

        // load the cache with divu 1000/10 so a surviving cache would be visible after reset
        vr = '{0, F3_DIVU, 32'd1000, 32'd10, 4'd5, 32'd100, 1'b0, 1'b0};
        run_vec(vr, "preload");

        // reset while the divider is busy on a signed div
        @(negedge clk); #1;
        drive(0, F3_DIV, 32'd1000, 32'd10, 4'd6);
        #1;
        wait_ready(0, ok);
        @(negedge clk); #1;
        bus.req_valid[0] = 1'b0;
        chk("rst.issue", 32'(div_start), 32'd1);
        @(negedge clk); #1;
        stall_force = 1'b1;
        rst_n = 1'b0;
        drive(0, F3_DIVU, 32'd1000, 32'd10, 4'd7);
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk); #1;
        rst_n = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            stray_done = (i == 4);
            chk($sformatf("rst_hold%0d.req_ready", i), 32'(bus.req_ready), 32'd0);
            chk($sformatf("rst_hold%0d.resp_valid", i), 32'(bus.resp_valid), 32'd0);
        end
        @(negedge clk); #1;
        stray_done = 1'b0;
        chk("rst_hold.starts", start_cnt, s0);
        chk("rst_hold.resp_valid", 32'(bus.resp_valid), 32'd0);
        bus.req_valid[0] = 1'b0;
        stall_force = 1'b0;

        // after reset the same divu must go to the divider again
        vr = '{0, F3_DIVU, 32'd1000, 32'd10, 4'd7, 32'd100, 1'b0, 1'b0};
        run_vec(vr, "rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
